// File: rtl/uart_stream_arbiter_if.sv
// Handshake bundle between the two byte-stream sources, the arbiter and uart_tx.
// master: the arbiter side; slave: the sources / uart_tx side.
interface uart_stream_arbiter_if;
    logic       src0_valid;
    logic [7:0] src0_data;
    logic       src0_last;
    logic       src0_ready;

    logic       src1_valid;
    logic [7:0] src1_data;
    logic       src1_last;
    logic       src1_ready;

    logic       uart_ready;
    logic [7:0] uart_data;
    logic       uart_clock_enable;

    logic [1:0] grant;
    logic       frame_abort;

    modport master (
        input  src0_valid, src0_data, src0_last,
        input  src1_valid, src1_data, src1_last,
        input  uart_ready,
        output src0_ready, src1_ready,
        output uart_data, uart_clock_enable,
        output grant, frame_abort
    );

    modport slave (
        output src0_valid, src0_data, src0_last,
        output src1_valid, src1_data, src1_last,
        output uart_ready,
        input  src0_ready, src1_ready,
        input  uart_data, uart_clock_enable,
        input  grant, frame_abort
    );
endinterface

// File: rtl/uart_stream_arbiter.sv
// Round-robin, frame-atomic sharing of one uart_tx between two byte streams,
// with an optional per-frame source tag byte and a mid-frame idle timeout.
module uart_stream_arbiter #(
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  HEADER_BASE = 8'hA0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_stream_arbiter_if.master bus
);
    localparam int unsigned     CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        GAP
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] idle_cnt_inc;
    logic [7:0]       uart_data_q, uart_data_d;
    logic             strobe_q, strobe_d;
    logic             abort_q, abort_d;

    logic             cur_src;
    logic             cur_valid;
    logic             cur_last;
    logic [7:0]       cur_data;
    logic             any_req;
    logic             pick;
    logic             accept;

    // The owning source is encoded by the one-hot grant itself.
    assign cur_src   = grant_q[1];
    assign cur_valid = cur_src ? bus.src1_valid : bus.src0_valid;
    assign cur_last  = cur_src ? bus.src1_last  : bus.src0_last;
    assign cur_data  = cur_src ? bus.src1_data  : bus.src0_data;

    assign bus.src0_ready = (state_q == DATA) && grant_q[0] && bus.uart_ready;
    assign bus.src1_ready = (state_q == DATA) && grant_q[1] && bus.uart_ready;

    assign accept = (state_q == DATA) && cur_valid && bus.uart_ready;

    assign any_req = bus.src0_valid || bus.src1_valid;

    always_comb begin
        pick = 1'b0;
        if (bus.src0_valid && bus.src1_valid) begin
            pick = ~last_grant_q;
        end else begin
            pick = bus.src1_valid;
        end
    end

    assign idle_cnt_inc = (idle_cnt_q == TIMEOUT_CNT) ? idle_cnt_q
                                                      : idle_cnt_q + CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            idle_cnt_q   <= '0;
            uart_data_q  <= '0;
            strobe_q     <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idle_cnt_q   <= idle_cnt_d;
            uart_data_q  <= uart_data_d;
            strobe_q     <= strobe_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idle_cnt_d   = '0;
        uart_data_d  = uart_data_q;
        strobe_d     = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (any_req) begin
                    grant_d      = pick ? 2'b10 : 2'b01;
                    last_grant_d = pick;
                    state_d      = HEADER_EN ? HEADER : DATA;
                end
            end

            HEADER: begin
                if (bus.uart_ready) begin
                    uart_data_d = HEADER_BASE | {7'b0, cur_src};
                    strobe_d    = 1'b1;
                    state_d     = GAP;
                    ret_d       = DATA;
                end
            end

            DATA: begin
                idle_cnt_d = idle_cnt_q;
                if (accept) begin
                    idle_cnt_d  = '0;
                    uart_data_d = cur_data;
                    strobe_d    = 1'b1;
                    state_d     = GAP;
                    ret_d       = cur_last ? IDLE : DATA;
                end else if (!cur_valid) begin
                    // Abort on the TIMEOUT-th idle cycle; last_grant keeps the
                    // aborted source so the other one wins the next tie.
                    if (idle_cnt_inc == TIMEOUT_CNT) begin
                        idle_cnt_d = '0;
                        abort_d    = 1'b1;
                        grant_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_inc;
                    end
                end
            end

            GAP: begin
                state_d = ret_q;
                if (ret_q == IDLE) begin
                    grant_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.uart_data         = uart_data_q;
    assign bus.uart_clock_enable = strobe_q;
    assign bus.grant             = grant_q;
    assign bus.frame_abort       = abort_q;
endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Scoreboard bench: stimulus queues source bytes and pushes the expected
// uart byte/grant sequence; a monitor compares on every uart load strobe.
module tb_uart_stream_arbiter;
    localparam int unsigned TB_TIMEOUT = 8;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        int unsigned idle;
    } item_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] g;
    } exp_t;

    logic clock;
    logic reset;

    uart_stream_arbiter_if bus ();

    uart_stream_arbiter #(
        .HEADER_EN   (1'b1),
        .HEADER_BASE (8'hA0),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    item_t       q0[$];
    item_t       q1[$];
    exp_t        exp_q[$];
    bit          loaded0, loaded1;
    int unsigned idle0, idle1;
    bit          uart_hold;
    int unsigned busy;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned strobes;
    int unsigned aborts;
    int unsigned exp_aborts;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic src_push(input int s, input logic [7:0] d, input logic l, input int unsigned idle);
        item_t it;
        it.d = d;
        it.l = l;
        it.idle = idle;
        if (s == 0) q0.push_back(it);
        else        q1.push_back(it);
    endtask

    task automatic exp_push(input logic [7:0] d, input logic [1:0] g);
        exp_t e;
        e.d = d;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: %0d bytes still expected after %0d cycles, required 0", name, exp_q.size(), budget);
        end
        repeat (6) @(negedge clock);
        #2;
        check({name, "_grant_idle"}, 32'(bus.grant), 32'h0);
    endtask

    // Source drivers: present the queue head after its idle delay, pop on handshake.
    initial begin
        item_t tmp;
        bus.src0_valid = 1'b0; bus.src0_data = '0; bus.src0_last = 1'b0;
        bus.src1_valid = 1'b0; bus.src1_data = '0; bus.src1_last = 1'b0;
        loaded0 = 1'b0; loaded1 = 1'b0; idle0 = 0; idle1 = 0;
        forever begin
            @(negedge clock);
            if (q0.size() > 0) begin
                if (!loaded0) begin idle0 = q0[0].idle; loaded0 = 1'b1; end
                if (idle0 > 0) begin
                    idle0--;
                    bus.src0_valid = 1'b0;
                end else begin
                    bus.src0_valid = 1'b1;
                    bus.src0_data  = q0[0].d;
                    bus.src0_last  = q0[0].l;
                end
            end else begin
                bus.src0_valid = 1'b0;
            end
            if (q1.size() > 0) begin
                if (!loaded1) begin idle1 = q1[0].idle; loaded1 = 1'b1; end
                if (idle1 > 0) begin
                    idle1--;
                    bus.src1_valid = 1'b0;
                end else begin
                    bus.src1_valid = 1'b1;
                    bus.src1_data  = q1[0].d;
                    bus.src1_last  = q1[0].l;
                end
            end else begin
                bus.src1_valid = 1'b0;
            end
            #3;
            if (reset && bus.src0_valid && bus.src0_ready && q0.size() > 0) begin
                tmp = q0.pop_front();
                loaded0 = 1'b0;
            end
            if (reset && bus.src1_valid && bus.src1_ready && q1.size() > 0) begin
                tmp = q1.pop_front();
                loaded1 = 1'b0;
            end
        end
    end

    // uart_tx model: busy for 3 cycles after each load strobe.
    initial begin
        busy = 0;
        bus.uart_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.uart_clock_enable) busy = 3;
            else if (busy > 0) busy--;
            bus.uart_ready = (busy == 0) && !uart_hold;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        bit   prev_strobe;
        bit   prev_abort;
        prev_strobe = 1'b0;
        prev_abort  = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (bus.uart_clock_enable) begin
                strobes++;
                check("strobe_spacing", 32'(prev_strobe), 32'h0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got byte 0x%0h grant 0x%0h, expected no strobe", bus.uart_data, bus.grant);
                end else begin
                    e = exp_q.pop_front();
                    check("uart_data", 32'(bus.uart_data), 32'(e.d));
                    check("strobe_grant", 32'(bus.grant), 32'(e.g));
                end
            end
            if (bus.frame_abort) begin
                aborts++;
                check("abort_single_pulse", 32'(prev_abort), 32'h0);
                check("abort_grant", 32'(bus.grant), 32'h0);
            end
            if (bus.src0_ready) begin
                check("src0_ready_owner", {29'h0, bus.grant, bus.uart_ready}, {29'h0, 2'b01, 1'b1});
            end
            if (bus.src1_ready) begin
                check("src1_ready_owner", {29'h0, bus.grant, bus.uart_ready}, {29'h0, 2'b10, 1'b1});
            end
            prev_strobe = bus.uart_clock_enable;
            prev_abort  = bus.frame_abort;
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_grant"}, 32'(bus.grant), 32'h0);
        check({name, "_uart_data"}, 32'(bus.uart_data), 32'h0);
        check({name, "_strobe"}, 32'(bus.uart_clock_enable), 32'h0);
        check({name, "_abort"}, 32'(bus.frame_abort), 32'h0);
        check({name, "_ready"}, {30'h0, bus.src1_ready, bus.src0_ready}, 32'h0);
    endtask

    initial begin
        int unsigned base;
        int unsigned n;
        n_checks = 0; n_fail = 0; strobes = 0; aborts = 0; exp_aborts = 0;
        uart_hold = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // 1: single source0 frame
        src_push(0, 8'h11, 1'b0, 0);
        src_push(0, 8'h22, 1'b0, 0);
        src_push(0, 8'h33, 1'b1, 0);
        exp_push(8'hA0, 2'b01); exp_push(8'h11, 2'b01);
        exp_push(8'h22, 2'b01); exp_push(8'h33, 2'b01);
        wait_drain("t1", 300);

        // 2: simultaneous requests straight after reset, source0 wins the tie
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        src_push(0, 8'h21, 1'b0, 0);
        src_push(0, 8'h22, 1'b1, 0);
        src_push(1, 8'h31, 1'b1, 0);
        exp_push(8'hA0, 2'b01); exp_push(8'h21, 2'b01); exp_push(8'h22, 2'b01);
        exp_push(8'hA1, 2'b10); exp_push(8'h31, 2'b10);
        wait_drain("t2", 300);

        // 3: source1 arrives mid-frame; four frames alternate
        src_push(0, 8'h41, 1'b0, 0);
        src_push(0, 8'h42, 1'b0, 0);
        src_push(0, 8'h43, 1'b1, 0);
        src_push(0, 8'h51, 1'b1, 0);
        src_push(1, 8'h61, 1'b0, 3);
        src_push(1, 8'h62, 1'b1, 0);
        src_push(1, 8'h71, 1'b1, 0);
        exp_push(8'hA0, 2'b01); exp_push(8'h41, 2'b01); exp_push(8'h42, 2'b01); exp_push(8'h43, 2'b01);
        exp_push(8'hA1, 2'b10); exp_push(8'h61, 2'b10); exp_push(8'h62, 2'b10);
        exp_push(8'hA0, 2'b01); exp_push(8'h51, 2'b01);
        exp_push(8'hA1, 2'b10); exp_push(8'h71, 2'b10);
        wait_drain("t3", 600);

        // 4: source0 stalls mid-frame past the timeout, source1 takes over
        src_push(0, 8'h44, 1'b0, 0);
        src_push(0, 8'h46, 1'b1, 20);
        src_push(1, 8'h55, 1'b1, 2);
        exp_push(8'hA0, 2'b01); exp_push(8'h44, 2'b01);
        exp_push(8'hA1, 2'b10); exp_push(8'h55, 2'b10);
        exp_push(8'hA0, 2'b01); exp_push(8'h46, 2'b01);
        exp_aborts++;
        wait_drain("t4", 400);
        check("t4_abort_count", aborts, exp_aborts);

        // 5: uart_tx held busy with a source waiting
        uart_hold = 1'b1;
        @(negedge clock);
        base = strobes;
        src_push(1, 8'h77, 1'b0, 0);
        src_push(1, 8'h78, 1'b1, 0);
        repeat (100) @(negedge clock);
        #2;
        check("t5_no_strobe", strobes, base);
        check("t5_no_abort", aborts, exp_aborts);
        check("t5_grant_held", 32'(bus.grant), 32'h2);
        check("t5_ready_low", {30'h0, bus.src1_ready, bus.src0_ready}, 32'h0);
        exp_push(8'hA1, 2'b10); exp_push(8'h77, 2'b10); exp_push(8'h78, 2'b10);
        uart_hold = 1'b0;
        wait_drain("t5", 300);

        // 6: asynchronous reset in the middle of a frame
        base = strobes;
        src_push(0, 8'h61, 1'b0, 0);
        src_push(0, 8'h62, 1'b0, 0);
        src_push(0, 8'h63, 1'b1, 0);
        exp_push(8'hA0, 2'b01); exp_push(8'h61, 2'b01);
        n = 0;
        while (strobes < base + 2 && n < 200) begin
            @(negedge clock);
            #2;
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL t6_wait: got %0d strobes, expected %0d", strobes - base, 2);
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async_reset");
        check("t6_exp_empty", exp_q.size(), 0);
        q0.delete();
        q1.delete();
        loaded0 = 1'b0;
        loaded1 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        src_push(0, 8'h71, 1'b0, 0);
        src_push(0, 8'h72, 1'b1, 0);
        src_push(1, 8'h81, 1'b1, 0);
        exp_push(8'hA0, 2'b01); exp_push(8'h71, 2'b01); exp_push(8'h72, 2'b01);
        exp_push(8'hA1, 2'b10); exp_push(8'h81, 2'b10);
        wait_drain("t6", 300);

        check("final_abort_count", aborts, exp_aborts);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
